// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive and transmit paths.
package uart_pkg;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead circular FIFO. The head is presented combinationally and reads 0 when empty.
// When the FIFO is full, a push is accepted in the same cycle as a pop. A pop while empty is ignored.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_DATA_BITS,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   // Next pointer and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array. It needs no reset because count_q gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. It contains the input synchroniser, the frame FSM, the shift register,
// the sticky error flags, and a show-ahead receive FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       overrun,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(UART_DATA_BITS - 1);

   logic       meta_q, meta_d;
   logic       rx_s_q, rx_s_d;
   logic       rx_d_q, rx_d_d;
   logic [1:0] fill_q, fill_d;     // counts reset-free edges until rx_d holds a real pin value
   rx_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic       overrun_q, overrun_d;
   logic       frame_err_q, frame_err_d;

   logic       line_live;
   logic       stop_ok, frame_evt, overrun_evt;
   logic       fifo_full, fifo_empty;

   // Synchroniser chain. Edge detection is disabled until the reset 1s have been flushed,
   // so a line that is held low through reset is not mistaken for a start bit.
   always_comb begin
      meta_d = rx;
      rx_s_d = meta_q;
      rx_d_d = rx_s_q;
      fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
   end

   assign line_live = (fill_q == 2'd3);

   // Frame FSM. It samples mid-bit, shifts the data in LSB first, and checks the stop bit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      stop_ok   = 1'b0;
      frame_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (line_live && rx_d_q && !rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               if (!rx_s_q) begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               shift_d[bit_idx_q] = rx_s_q;
               cnt_d = '0;
               if (bit_idx_q == IDX_LAST) state_d = STOP;
               else bit_idx_d = bit_idx_q + BW'(1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (rx_s_q) stop_ok   = 1'b1;
               else        frame_evt = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completed byte is lost only if the FIFO is full and no pop frees a slot in the same cycle.
   assign overrun_evt = stop_ok && fifo_full && !rd_en;

   // Sticky error flags. When a new error arrives in the same cycle as a clear, the error wins.
   always_comb begin
      overrun_d   = clr_err ? 1'b0 : overrun_q;
      frame_err_d = clr_err ? 1'b0 : frame_err_q;
      if (overrun_evt) overrun_d   = 1'b1;
      if (frame_evt)   frame_err_d = 1'b1;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_d_q      <= 1'b1;
         fill_q      <= 2'd0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         rx_s_q      <= rx_s_d;
         rx_d_q      <= rx_d_d;
         fill_q      <= fill_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (stop_ok),
      .pop   (rd_en),
      .din   (shift_q),
      .dout  (rx_byte),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_valid  = !fifo_empty;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. It drives whole serial frames and compares the DUT outputs
// against a byte-queue model of the receive buffer and the error flags.
module tb_uart_rx;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, rx, rd_en, clr_err;
   logic [7:0] rx_byte;
   logic       rx_valid, overrun, frame_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] model_q[$];
   logic       model_ovr;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   // ---------------- model and stimulus helpers ----------------
   function automatic void model_rx(input logic [7:0] b);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else model_ovr = 1'b1;
   endfunction

   function automatic void model_pop();
      if (model_q.size() > 0) void'(model_q.pop_front());
   endfunction

   function automatic logic [7:0] exp_head();
      return (model_q.size() > 0) ? model_q[0] : 8'h00;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive the first nbits bit-periods of a frame: start, d0..d7, stop.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         rx = fr[i];
         idle(CPB);
      end
   endtask

   task automatic pulse_rd();
      rd_en = 1'b1;
      idle(1);
      rd_en = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; rx = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      idle(3);
      total++;
      if (rx_valid !== 1'b0 || rx_byte !== 8'h00 || overrun !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got valid=%b byte=%h ovr=%b ferr=%b want 0 00 0 0",
                  rx_valid, rx_byte, overrun, frame_err);
      end
      rst = 1'b0;
      idle(12 * CPB);               // line held low out of reset
      total++;
      if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL low_after_reset: got valid=%b ferr=%b want 0 0", rx_valid, frame_err);
      end
      rx = 1'b1;
      idle(3 * CPB);
      model_q.delete();
      model_ovr = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single_byte();
      fork
         send_frame(8'hA5, 1'b1, 10);
         begin
            idle(78);
            total++;
            if (rx_valid !== 1'b0) begin
               bad++;
               $display("FAIL single_early: got valid=%b want 0", rx_valid);
            end
            idle(1);
            total++;
            if (rx_valid !== 1'b1 || rx_byte !== 8'hA5) begin
               bad++;
               $display("FAIL single_latency: got valid=%b byte=%h want 1 a5", rx_valid, rx_byte);
            end
         end
      join
      model_rx(8'hA5);
      pulse_rd();
      model_pop();
      total++;
      if (rx_valid !== 1'b0 || rx_byte !== exp_head()) begin
         bad++;
         $display("FAIL single_pop: got valid=%b byte=%h want 0 %h", rx_valid, rx_byte, exp_head());
      end
      $display("test_single_byte done");
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      idle(2);
      rx = 1'b1;
      idle(3 * CPB);
      total++;
      if (rx_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL glitch: got valid=%b ovr=%b ferr=%b want 0 0 0", rx_valid, overrun, frame_err);
      end
      send_frame(8'h5A, 1'b1, 10);
      model_rx(8'h5A);
      total++;
      if (rx_valid !== 1'b1 || rx_byte !== exp_head()) begin
         bad++;
         $display("FAIL glitch_recover: got valid=%b byte=%h want 1 %h", rx_valid, rx_byte, exp_head());
      end
      pulse_rd();
      model_pop();
      $display("test_glitch done");
   endtask

   task automatic test_frame_error();
      send_frame(8'h3C, 1'b0, 10);   // the line stays low afterwards (break)
      total++;
      if (frame_err !== 1'b1 || rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL ferr_set: got ferr=%b valid=%b want 1 0", frame_err, rx_valid);
      end
      idle(4 * CPB);
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_clear: got %b want 0", frame_err);
      end
      idle(12 * CPB);
      total++;
      if (frame_err !== 1'b0 || rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL break_once: got ferr=%b valid=%b want 0 0", frame_err, rx_valid);
      end
      rx = 1'b1;
      idle(2 * CPB);
      send_frame(8'h3C, 1'b1, 10);
      model_rx(8'h3C);
      total++;
      if (rx_valid !== 1'b1 || rx_byte !== exp_head() || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_recover: got valid=%b byte=%h ferr=%b want 1 %h 0",
                  rx_valid, rx_byte, frame_err, exp_head());
      end
      pulse_rd();
      model_pop();
      // A clear in the same cycle as a new stop-bit error must lose to the error.
      fork
         send_frame(8'hC3, 1'b0, 10);
         begin
            idle(78);
            clr_err = 1'b1;
            idle(1);
            clr_err = 1'b0;
         end
      join
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL ferr_vs_clear: got %b want 1", frame_err);
      end
      rx = 1'b1;
      idle(2 * CPB);
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      $display("test_frame_error done");
   endtask

   task automatic test_overrun();
      for (int b = 1; b <= 5; b++) begin
         send_frame(8'(b), 1'b1, 10);
         model_rx(8'(b));
      end
      total++;
      if (overrun !== model_ovr) begin
         bad++;
         $display("FAIL ovr_set: got %b want %b", overrun, model_ovr);
      end
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (rx_valid !== 1'b1 || rx_byte !== exp_head()) begin
            bad++;
            $display("FAIL ovr_drain%0d: got valid=%b byte=%h want 1 %h", i, rx_valid, rx_byte, exp_head());
         end
         pulse_rd();
         model_pop();
      end
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL ovr_empty: got valid=%b want 0", rx_valid);
      end
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      model_ovr = 1'b0;
      // Refill the FIFO. Then pop on the stop-sample edge of a fifth frame.
      for (int b = 1; b <= 4; b++) begin
         send_frame(8'(b), 1'b1, 10);
         model_rx(8'(b));
      end
      fork
         send_frame(8'h05, 1'b1, 10);
         begin
            idle(78);
            rd_en = 1'b1;
            idle(1);
            rd_en = 1'b0;
         end
      join
      model_pop();
      model_rx(8'h05);
      total++;
      if (overrun !== model_ovr) begin
         bad++;
         $display("FAIL full_pop_push_ovr: got %b want %b", overrun, model_ovr);
      end
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (rx_valid !== 1'b1 || rx_byte !== exp_head()) begin
            bad++;
            $display("FAIL full_drain%0d: got valid=%b byte=%h want 1 %h", i, rx_valid, rx_byte, exp_head());
         end
         pulse_rd();
         model_pop();
      end
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_empty: got valid=%b want 0", rx_valid);
      end
      $display("test_overrun done");
   endtask

   task automatic test_wrap();
      for (int b = 8'h10; b <= 8'h1A; b++) begin
         send_frame(8'(b), 1'b1, 10);
         model_rx(8'(b));
         total++;
         if (rx_valid !== 1'b1 || rx_byte !== exp_head()) begin
            bad++;
            $display("FAIL wrap_%h: got valid=%b byte=%h want 1 %h", 8'(b), rx_valid, rx_byte, exp_head());
         end
         pulse_rd();
         model_pop();
      end
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL wrap_empty: got valid=%b want 0", rx_valid);
      end
      $display("test_wrap done");
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h55, 1'b1, 5);    // start bit plus d0..d3
      rx = 1'b1;                     // d4 of 0x55
      idle(4);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      model_q.delete();
      model_ovr = 1'b0;
      idle(3 * CPB);
      total++;
      if (rx_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL midreset_state: got valid=%b ovr=%b ferr=%b want 0 0 0", rx_valid, overrun, frame_err);
      end
      send_frame(8'h66, 1'b1, 10);
      model_rx(8'h66);
      total++;
      if (rx_valid !== 1'b1 || rx_byte !== exp_head() || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL midreset_rx: got valid=%b byte=%h ferr=%b want 1 %h 0", rx_valid, rx_byte, frame_err, exp_head());
      end
      pulse_rd();
      model_pop();
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_only: got valid=%b want 0", rx_valid);
      end
      $display("test_reset_midframe done");
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         npop;
      for (int n = 0; n < 16; n++) begin
         b = 8'($urandom);
         idle($urandom_range(0, 5));
         send_frame(b, 1'b1, 10);
         model_rx(b);
         total++;
         if (rx_valid !== (model_q.size() > 0) || rx_byte !== exp_head() || overrun !== model_ovr) begin
            bad++;
            $display("FAIL rand_%0d: got valid=%b byte=%h ovr=%b want %b %h %b", n, rx_valid, rx_byte,
                     overrun, (model_q.size() > 0), exp_head(), model_ovr);
         end
         npop = $urandom_range(0, 2);
         for (int k = 0; k < npop; k++) begin
            pulse_rd();
            model_pop();
         end
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         total++;
         if (rx_valid !== (model_q.size() > 0) || rx_byte !== exp_head()) begin
            bad++;
            $display("FAIL rand_drain%0d: got valid=%b byte=%h want %b %h", i, rx_valid, rx_byte,
                     (model_q.size() > 0), exp_head());
         end
         pulse_rd();
         model_pop();
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_wrap();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART console: the receive-side counterpart of the existing transmit path. It deserialises 8N1 frames from the `rx` pin into bytes and buffers them in a small FIFO. It exposes the FIFO head, status flags and a pop strobe to the memory map, which maps them as RX_READY/RX_BYTE registers next to UART_TX_READY/UART_TX_BYTE. CPU software polls RX_READY, then reads RX_BYTE, which pops the byte.

## Interface
- `CLKS_PER_BIT`, 434, `clk` cycles per bit (50 MHz / 115200 baud); must be ≥ 4.
- `FIFO_DEPTH`, 8, receive buffer entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `rx`  in  1  asynchronous serial line; idles high.
- `rd_en`  in  1  pop strobe, one cycle per byte; ignored when empty.
- `clr_err`  in  1  clears `overrun` and `frame_err`.
- `rx_byte`  out  8  FIFO head (show-ahead); 0 when empty.
- `rx_valid`  out  1  FIFO not empty.
- `overrun`  out  1  sticky: completed byte dropped because FIFO full.
- `frame_err`  out  1  sticky: stop bit sampled low.

## Operation
- **Input synchroniser.** `rx` passes through 2 flops (reset value 1) to give `rx_s`; the previous value is kept as `rx_d`.
- **FSM states.** IDLE, START, DATA, STOP.
- **IDLE.**
  - `rx_d`=1 and `rx_s`=0 (falling edge) → START, with bit counter `cnt`=0.
  - A line held low out of reset never starts a frame.
- **START.**
  - At `cnt`=CLKS_PER_BIT/2−1 (integer division), sample `rx_s`.
  - Sample 0 → DATA, `cnt`=0, `bit_idx`=0.
  - Sample 1 → IDLE (glitch rejected, nothing recorded).
- **DATA.**
  - At `cnt`=CLKS_PER_BIT−1, sample `rx_s` into `shift[bit_idx]`, LSB first, and reset `cnt`.
  - After `bit_idx`=7 → STOP.
- **STOP.** At `cnt`=CLKS_PER_BIT−1, sample, then → IDLE:
  - Sample 1, FIFO accepts → push `shift`.
  - Sample 1, FIFO cannot accept → set `overrun`, drop the byte.
  - Sample 0 → set `frame_err`, drop the byte, no push. IDLE then waits for a fresh falling edge, so a break (line held low) yields exactly one frame error.
- **FIFO.** Circular buffer with read pointer, write pointer and count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- **Simultaneous push and pop.**
  - When full, pop-then-push is allowed: the push is accepted, no overrun, count unchanged.
  - When empty, the push is accepted and the pop is ignored; count becomes 1.
- **Flags.**
  - `clr_err` in the same cycle as a new error event: the new error wins and the flag stays 1.
- **Reset.** Mid-frame reset: FSM → IDLE, FIFO empty, flags 0, synchroniser 1s. Any partial byte is discarded.
- **Reset values.** `rx_byte`=0, `rx_valid`=0, `overrun`=0, `frame_err`=0.

## Timing
- **Start detection.** The falling edge at the pin is seen in IDLE 2 cycles later, because of the synchroniser.
- **Sample points.** Relative to the detected edge at cycle 0:
  - start-bit sample at cycle CLKS_PER_BIT/2;
  - data bit k sample at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop-bit sample at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- **Push latency.** The push is registered on the stop-sample edge; `rx_valid`/`rx_byte` update on the following cycle.
- **Pop.** `rd_en` at edge N gives the new head, or `rx_valid`=0, after edge N. The memory map must pulse `rd_en` for exactly one cycle per CPU read.
- **Back-to-back frames.** A new start edge is accepted on the first IDLE cycle after STOP. This tolerates up to about CLKS_PER_BIT/2 of transmitter clock skew per frame.
- **Error flags** assert on the cycle after the stop sample.

## Structure
- **Shared package `uart_pkg`:**
  - `rx_state_t` enum {IDLE, START, DATA, STOP};
  - `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT`=434.
  - The transmitter is to reuse the same constants.
- **Sub-module `sync_fifo`:**
  - parameters WIDTH=8 and DEPTH;
  - ports push, pop, din, dout, full, empty;
  - show-ahead.
- **Top level** holds the synchroniser, FSM, counters, shift register and flags.

## Test plan
- **Single byte.** CLKS_PER_BIT=8, send 0xA5 8N1 → `rx_valid`=1 with `rx_byte`=0xA5 one cycle after the stop sample. Pulse `rd_en` → `rx_valid`=0, `rx_byte`=0.
- **Glitch rejection.** Drive `rx` low for 2 cycles, then high → no state change past START, FIFO empty, no flags set.
- **Frame error.** Send 0x3C with stop bit 0 → `frame_err`=1, FIFO empty. Pulse `clr_err` → 0. Then send 0x3C correctly → received normally.
- **Overrun, then full boundary.**
  - FIFO_DEPTH=4: send 0x01–0x05 without popping → 0x01–0x04 stored, `overrun`=1.
  - Refill to full, then assert `rd_en` on the 5th stop-sample cycle → 0x01 popped, new byte accepted, count stays 4, `overrun` unchanged.
- **Wrap-around.** Send and pop 11 bytes 0x10–0x1A one at a time with FIFO_DEPTH=4 → every byte is read in order and both pointers wrap.
- **Reset mid-frame.** Assert `rst` during data bit 4 of 0x55, then send 0x66 → only 0x66 is received, no flags.
